// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared constants and MEM/WB record for the write-back stage
package wb_stage_pkg;

    localparam int WB_DATA_W  = 32;
    localparam int WB_ADDR_W  = 5;
    localparam int WB_REG_NUM = 32;

    localparam logic RST_ENABLE    = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

    localparam logic [WB_DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic [WB_ADDR_W-1:0] NOP_REG_ADDR = '0;

    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] waddr;
        logic [WB_DATA_W-1:0] data;
        logic                 valid;
    } memwb_t;

    function automatic memwb_t memwb_bubble();
        memwb_t b;
        b.we    = WRITE_DISABLE;
        b.waddr = NOP_REG_ADDR;
        b.data  = ZERO_WORD;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-side, ID-read-side and forwarding signals of the write-back stage
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic [WB_DATA_W-1:0] mem_data_i;
    logic                 mem_we_i;
    logic [WB_ADDR_W-1:0] mem_waddr_i;
    logic                 mem_valid_i;
    logic                 mem_stall_i;
    logic                 wb_stall_i;
    logic                 flush_i;
    logic                 re1_i;
    logic [WB_ADDR_W-1:0] raddr1_i;
    logic [WB_DATA_W-1:0] rdata1_o;
    logic                 re2_i;
    logic [WB_ADDR_W-1:0] raddr2_i;
    logic [WB_DATA_W-1:0] rdata2_o;
    logic                 wb_we_o;
    logic [WB_ADDR_W-1:0] wb_waddr_o;
    logic [WB_DATA_W-1:0] wb_data_o;
    logic [31:0]          retired_o;

    modport master (
        output mem_data_i, mem_we_i, mem_waddr_i, mem_valid_i,
        output mem_stall_i, wb_stall_i, flush_i,
        output re1_i, raddr1_i, re2_i, raddr2_i,
        input  rdata1_o, rdata2_o, wb_we_o, wb_waddr_o, wb_data_o, retired_o
    );

    modport slave (
        input  mem_data_i, mem_we_i, mem_waddr_i, mem_valid_i,
        input  mem_stall_i, wb_stall_i, flush_i,
        input  re1_i, raddr1_i, re2_i, raddr2_i,
        output rdata1_o, rdata2_o, wb_we_o, wb_waddr_o, wb_data_o, retired_o
    );

endinterface

// File: rtl/wb_stage_regfile.sv
// rtl/wb_stage_regfile.sv - 32x32 register file, one write port, two write-first bypassed read ports
module wb_stage_regfile
    import wb_stage_pkg::*;
#(
    parameter int DATA_W  = WB_DATA_W,
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int REG_NUM = WB_REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_commit,
    input  logic              i_re1,
    input  logic [ADDR_W-1:0] i_raddr1,
    output logic [DATA_W-1:0] o_rdata1,
    input  logic              i_re2,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata2
);

    logic [DATA_W-1:0] r_regs [REG_NUM];
    logic              w_wr_ok;

    assign w_wr_ok = i_commit && (i_waddr != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Bypass follows the pending WB entry even while stalled, so ID never sees stale data.
    function automatic logic [DATA_W-1:0] read_port(input logic re, input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] v;
        v = '0;
        if (rst == RST_ENABLE || re == READ_DISABLE || ra == '0) begin
            v = '0;
        end else if (ra == i_waddr && i_we == WRITE_ENABLE) begin
            v = i_wdata;
        end else begin
            v = r_regs[ra];
        end
        return v;
    endfunction

    always_comb begin
        o_rdata1 = '0;
        o_rdata2 = '0;
        o_rdata1 = read_port(i_re1, i_raddr1);
        o_rdata2 = read_port(i_re2, i_raddr2);
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register with stall/flush priority, register file commit and retire counter
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W  = WB_DATA_W,
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int REG_NUM = WB_REG_NUM
) (
    input  logic  clk,
    input  logic  rst,
    wb_stage_if.slave bus
);

    memwb_t      r_memwb;
    logic [31:0] r_retired;
    logic        w_retire;
    logic        w_commit;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_memwb <= memwb_bubble();
        end else if (bus.flush_i) begin
            r_memwb <= memwb_bubble();
        end else if (bus.wb_stall_i) begin
            r_memwb <= r_memwb;
        end else if (bus.mem_stall_i) begin
            r_memwb <= memwb_bubble();
        end else begin
            r_memwb.we    <= bus.mem_we_i;
            r_memwb.waddr <= bus.mem_waddr_i;
            r_memwb.data  <= bus.mem_data_i;
            r_memwb.valid <= bus.mem_valid_i;
        end
    end

    // A flushed entry is discarded outright: neither committed nor counted.
    assign w_retire = r_memwb.valid && !bus.wb_stall_i && !bus.flush_i;
    assign w_commit = (r_memwb.we == WRITE_ENABLE) && !bus.wb_stall_i && !bus.flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    wb_stage_regfile #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .REG_NUM (REG_NUM)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (r_memwb.we),
        .i_waddr  (r_memwb.waddr),
        .i_wdata  (r_memwb.data),
        .i_commit (w_commit),
        .i_re1    (bus.re1_i),
        .i_raddr1 (bus.raddr1_i),
        .o_rdata1 (bus.rdata1_o),
        .i_re2    (bus.re2_i),
        .i_raddr2 (bus.raddr2_i),
        .o_rdata2 (bus.rdata2_o)
    );

    assign bus.wb_we_o    = r_memwb.we;
    assign bus.wb_waddr_o = r_memwb.waddr;
    assign bus.wb_data_o  = r_memwb.data;
    assign bus.retired_o  = r_retired;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed-vector bench for the write-back stage
module tb_wb_stage;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    wb_stage_if bus ();

    wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem(input logic we, input logic [4:0] wa, input logic [31:0] d, input logic v);
        bus.mem_we_i    = we;
        bus.mem_waddr_i = wa;
        bus.mem_data_i  = d;
        bus.mem_valid_i = v;
    endtask

    task automatic idle_mem();
        drive_mem(1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic set_rd(input logic [4:0] a1, input logic [4:0] a2);
        bus.raddr1_i = a1;
        bus.raddr2_i = a2;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        idle_mem();
        bus.mem_stall_i = 1'b0;
        bus.wb_stall_i  = 1'b0;
        bus.flush_i     = 1'b0;
        bus.re1_i       = 1'b1;
        bus.re2_i       = 1'b1;
        bus.raddr1_i    = 5'd5;
        bus.raddr2_i    = 5'd0;
        tick();
        tick();
        check_vec("rst_wb_we",   {31'd0, bus.wb_we_o}, 32'd0);
        check_vec("rst_wb_data", bus.wb_data_o, 32'd0);
        check_vec("rst_retired", bus.retired_o, 32'd0);
        check_vec("rst_rdata1",  bus.rdata1_o, 32'd0);
        rst = 1'b1;

        // Basic write to r5 with bypass then storage read.
        tick();
        drive_mem(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
        tick();
        idle_mem();
        set_rd(5'd5, 5'd0);
        check_vec("w5_wb_we",    {31'd0, bus.wb_we_o}, 32'd1);
        check_vec("w5_wb_waddr", {27'd0, bus.wb_waddr_o}, 32'd5);
        check_vec("w5_wb_data",  bus.wb_data_o, 32'hDEADBEEF);
        check_vec("w5_bypass",   bus.rdata1_o, 32'hDEADBEEF);
        check_vec("w5_ret0",     bus.retired_o, 32'd0);
        tick();
        check_vec("w5_wb_we_off", {31'd0, bus.wb_we_o}, 32'd0);
        check_vec("w5_stored",    bus.rdata1_o, 32'hDEADBEEF);
        check_vec("w5_ret1",      bus.retired_o, 32'd1);
        bus.re1_i = 1'b0;
        #1;
        check_vec("re1_off", bus.rdata1_o, 32'd0);
        bus.re1_i = 1'b1;

        // Write to r0 is discarded but still retires.
        drive_mem(1'b1, 5'd0, 32'h12345678, 1'b1);
        tick();
        idle_mem();
        set_rd(5'd0, 5'd0);
        check_vec("r0_wb_data", bus.wb_data_o, 32'h12345678);
        check_vec("r0_bypass",  bus.rdata1_o, 32'd0);
        tick();
        check_vec("r0_after",   bus.rdata1_o, 32'd0);
        check_vec("r0_ret2",    bus.retired_o, 32'd2);

        // WB stall holds r7 write for three edges; MEM input during stall is dropped.
        drive_mem(1'b1, 5'd7, 32'hA5A5A5A5, 1'b1);
        tick();
        drive_mem(1'b1, 5'd3, 32'h11111111, 1'b1);
        bus.wb_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_vec("stall_waddr", {27'd0, bus.wb_waddr_o}, 32'd7);
            check_vec("stall_data",  bus.wb_data_o, 32'hA5A5A5A5);
            check_vec("stall_ret",   bus.retired_o, 32'd2);
        end
        bus.wb_stall_i = 1'b0;
        idle_mem();
        tick();
        set_rd(5'd3, 5'd7);
        check_vec("stall_commit_r7", bus.rdata2_o, 32'hA5A5A5A5);
        check_vec("stall_r3_clean",  bus.rdata1_o, 32'd0);
        check_vec("stall_ret3",      bus.retired_o, 32'd3);
        check_vec("stall_wb_we_off", {31'd0, bus.wb_we_o}, 32'd0);

        // MEM stall inserts a bubble.
        drive_mem(1'b1, 5'd4, 32'h44444444, 1'b1);
        bus.mem_stall_i = 1'b1;
        tick();
        bus.mem_stall_i = 1'b0;
        idle_mem();
        set_rd(5'd4, 5'd0);
        check_vec("mstall_wb_we", {31'd0, bus.wb_we_o}, 32'd0);
        check_vec("mstall_r4",    bus.rdata1_o, 32'd0);
        tick();
        check_vec("mstall_r4_b",  bus.rdata1_o, 32'd0);
        check_vec("mstall_ret",   bus.retired_o, 32'd3);

        // Flush together with WB stall kills a pending r9 write.
        drive_mem(1'b1, 5'd9, 32'h00000099, 1'b1);
        tick();
        idle_mem();
        tick();
        drive_mem(1'b1, 5'd9, 32'h00000BAD, 1'b1);
        tick();
        idle_mem();
        set_rd(5'd9, 5'd0);
        check_vec("flush_pre_ret",  bus.retired_o, 32'd4);
        check_vec("flush_pre_byp",  bus.rdata1_o, 32'h00000BAD);
        bus.flush_i    = 1'b1;
        bus.wb_stall_i = 1'b1;
        tick();
        bus.flush_i    = 1'b0;
        bus.wb_stall_i = 1'b0;
        #1;
        check_vec("flush_wb_we",    {31'd0, bus.wb_we_o}, 32'd0);
        check_vec("flush_wb_waddr", {27'd0, bus.wb_waddr_o}, 32'd0);
        check_vec("flush_wb_data",  bus.wb_data_o, 32'd0);
        check_vec("flush_r9",       bus.rdata1_o, 32'h00000099);
        check_vec("flush_ret",      bus.retired_o, 32'd4);
        tick();
        check_vec("flush_r9_b",     bus.rdata1_o, 32'h00000099);
        check_vec("flush_ret_b",    bus.retired_o, 32'd4);

        // Counter wrap on a valid non-writing retire.
        force dut.r_retired = 32'hFFFFFFFF;
        #1;
        release dut.r_retired;
        #1;
        check_vec("wrap_pre", bus.retired_o, 32'hFFFFFFFF);
        drive_mem(1'b0, 5'd0, 32'h0, 1'b1);
        tick();
        idle_mem();
        check_vec("wrap_hold", bus.retired_o, 32'hFFFFFFFF);
        tick();
        check_vec("wrap_zero", bus.retired_o, 32'd0);

        // Reset asserted with a write pending.
        drive_mem(1'b1, 5'd10, 32'h10101010, 1'b1);
        tick();
        idle_mem();
        tick();
        drive_mem(1'b1, 5'd11, 32'h11110000, 1'b1);
        tick();
        idle_mem();
        set_rd(5'd10, 5'd11);
        check_vec("prerst_r10", bus.rdata1_o, 32'h10101010);
        check_vec("prerst_r11", bus.rdata2_o, 32'h11110000);
        check_vec("prerst_ret", bus.retired_o, 32'd1);
        rst = 1'b0;
        #1;
        check_vec("mrst_wb_we", {31'd0, bus.wb_we_o}, 32'd0);
        check_vec("mrst_r10",   bus.rdata1_o, 32'd0);
        check_vec("mrst_r11",   bus.rdata2_o, 32'd0);
        check_vec("mrst_ret",   bus.retired_o, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        set_rd(5'd5, 5'd11);
        check_vec("postrst_r5",  bus.rdata1_o, 32'd0);
        check_vec("postrst_r11", bus.rdata2_o, 32'd0);
        check_vec("postrst_ret", bus.retired_o, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back end of the 5-stage MIPS pipeline. Sits directly downstream of the MEM stage.
- Latches MEM's result (data, write enable, destination address, valid) into a MEM/WB pipeline register with stall/flush control.
- Commits the latched write into the 32x32 general register file and serves the ID stage's two combinational read ports with write-first bypass.
- Keeps a retired-instruction counter.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width
- REG_NUM, 32, number of architectural registers (2**ADDR_W)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset (`RstEnable == 1'b0)
- mem_data_i  in  DATA_W  result from MEM stage
- mem_we_i  in  1  register write enable from MEM
- mem_waddr_i  in  ADDR_W  destination register from MEM
- mem_valid_i  in  1  MEM slot holds a real instruction (not a bubble)
- mem_stall_i  in  1  MEM stage stalled this cycle
- wb_stall_i  in  1  WB stage stalled this cycle
- flush_i  in  1  exception/flush: discard MEM/WB contents
- re1_i  in  1  read port 1 enable
- raddr1_i  in  ADDR_W  read port 1 address
- rdata1_o  out  DATA_W  read port 1 data
- re2_i  in  1  read port 2 enable
- raddr2_i  in  ADDR_W  read port 2 address
- rdata2_o  out  DATA_W  read port 2 data
- wb_we_o  out  1  registered write enable (to ID forwarding)
- wb_waddr_o  out  ADDR_W  registered destination (to ID forwarding)
- wb_data_o  out  DATA_W  registered write data (to ID forwarding)
- retired_o  out  32  count of retired valid instructions

Behaviour:
- Reset (rst low, asynchronous):
  - MEM/WB register cleared: we=0, waddr=0, data=0, valid=0.
  - All REG_NUM registers cleared to 0; retired_o=0.
  - While rst is low, rdata1_o and rdata2_o read 0.
- MEM/WB register update at posedge clk, in strict priority order:
  1. flush_i=1: load bubble (we=0, waddr=0, data=0, valid=0).
  2. wb_stall_i=1: hold all fields.
  3. mem_stall_i=1 (and wb_stall_i=0): load bubble.
  4. Otherwise capture mem_* inputs.
- Latency: a MEM result appears on wb_*_o one cycle after capture. It is written into the register file on the following posedge and is visible on the read ports in the same cycle it sits in MEM/WB, via bypass.
- Register file write, at posedge clk:
  - Occurs when wb_we_o=1, wb_waddr_o!=0 and wb_stall_i=0.
  - Writes to register 0 are discarded.
  - When wb_stall_i=1 the pending write is not committed that cycle. It commits once, on the first unstalled edge.
- Read ports (combinational, each port independent), first matching rule wins:
  1. re=0 -> 0.
  2. raddr=0 -> 0.
  3. raddr==wb_waddr_o and wb_we_o=1 -> wb_data_o (write-first bypass).
  4. Otherwise the stored register value.
- Retire counter:
  - Increments by 1 on each posedge where MEM/WB valid=1, wb_stall_i=0 and flush_i=0.
  - A valid entry with we=0 still counts, e.g. a store or branch.
  - Wraps 0xFFFFFFFF -> 0.
  - flush_i discards the current entry without counting it.
- Simultaneous events:
  - flush_i together with wb_stall_i: flush wins, and the pending write is not committed.
  - Reset asserted mid-stall or mid-write: everything clears immediately and no partial write survives.

Decomposition:
- Shared global.v defines: `RstEnable (1'b0), `ZeroWord (32'h0), `NOPRegAddr (5'h0), `RegNum (32), `WriteEnable/`WriteDisable, `ReadEnable/`ReadDisable.
- One sub-module: regfile. It holds the storage array, the write port, the two bypassed read ports and the reset clear.
- wb_stage itself holds the MEM/WB register, the stall/flush priority logic and the retire counter.

Test Plan:
- Reset released, then mem_we_i=1, waddr=5, data=0xDEADBEEF, valid=1 -> next cycle wb_*_o show it and rdata1_o(raddr1=5, re1=1) = 0xDEADBEEF via bypass. One cycle later it reads from storage, still 0xDEADBEEF, and retired_o=1.
- Write to r0 with data 0x12345678 -> rdata for raddr=0 stays 0 in both the bypass cycle and afterward; retired_o still increments.
- wb_stall_i=1 for 3 cycles holding waddr=7, data=0xA5A5A5A5 -> wb_*_o unchanged, r7 not updated until the stall drops, retired_o increments exactly once.
- mem_stall_i=1 with wb_stall_i=0 -> wb_we_o=0 and valid=0 next cycle (bubble), no register change, counter unchanged.
- flush_i=1 together with wb_stall_i=1 on a pending write to r9 -> MEM/WB cleared, r9 keeps its old value, retired_o unchanged.
- Preset retired_o to 0xFFFFFFFF via 2^32-1 retirements (or a force) -> next valid retire gives 0. Assert rst low mid-sequence -> all outputs and registers read 0 immediately.
